// File: rtl/stk_pipe_al.sv
// Stack-line allocator: circular free-list FIFO, self-initialising after reset.
// Optional double-free detection bitmap enabled by defining STK_AL_DBLFREE_CHK_EN.
module stk_pipe_al #(
  parameter int LINES_N = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_alloc,
  input  logic                       i_free,
  input  logic [$clog2(LINES_N)-1:0] i_free_ptr,
  output logic                       o_alloc_vld_r,
  output logic [$clog2(LINES_N)-1:0] o_alloc_ptr_r,
  output logic                       o_empty_r,
  output logic                       o_busy_r,
  output logic [$clog2(LINES_N):0]   o_free_cnt_r,
  output logic                       o_err_r
);
  localparam int PTR_W = $clog2(LINES_N);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(LINES_N);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LINES_N - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic             empty_q, empty_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic [PTR_W-1:0] mem_q [LINES_N];
  logic             wr_en;
  logic [PTR_W-1:0] wr_data;
  logic [PTR_W-1:0] head;
  logic             ready, alloc_acc, free_acc, free_ok;

  assign head  = mem_q[rd_q];
  assign ready = (state_q == READY);

`ifdef STK_AL_DBLFREE_CHK_EN
  logic [LINES_N-1:0] map_q, map_d;

  // A free is legal only for a line currently handed out.
  assign free_ok = map_q[i_free_ptr];

  always_comb begin
    map_d = map_q;
    if (alloc_acc) map_d[head] = 1'b1;
    if (free_acc)  map_d[i_free_ptr] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) map_q <= '0;
    else     map_q <= map_d;
  end
`else
  assign free_ok = 1'b1;
`endif

  assign alloc_acc = ready & i_alloc & ~empty_q;
  assign free_acc  = ready & i_free & (cnt_q < FULL_CNT) & free_ok;

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    vld_d   = 1'b0;
    wr_en   = 1'b0;
    wr_data = i_free_ptr;
    if (state_q == INIT) begin
      // During init the write pointer doubles as the line index being seeded.
      wr_en   = 1'b1;
      wr_data = wr_q;
      wr_d    = wr_q + 1'b1;
      cnt_d   = cnt_q + 1'b1;
      if (wr_q == LAST_PTR) state_d = READY;
    end else begin
      if (alloc_acc) begin
        rd_d  = rd_q + 1'b1;
        ptr_d = head;
        vld_d = 1'b1;
      end
      if (free_acc) begin
        wr_en = 1'b1;
        wr_d  = wr_q + 1'b1;
      end
      if (alloc_acc && !free_acc)      cnt_d = cnt_q - 1'b1;
      else if (free_acc && !alloc_acc) cnt_d = cnt_q + 1'b1;
    end
    empty_d = (cnt_d == '0);
    busy_d  = (state_d == INIT);
    err_d   = err_q | (i_alloc & ~alloc_acc) | (i_free & ~free_acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      vld_q   <= 1'b0;
      empty_q <= 1'b1;
      busy_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
      empty_q <= empty_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= wr_data;
  end

  assign o_alloc_vld_r = vld_q;
  assign o_alloc_ptr_r = ptr_q;
  assign o_empty_r     = empty_q;
  assign o_busy_r      = busy_q;
  assign o_free_cnt_r  = cnt_q;
  assign o_err_r       = err_q;
endmodule

// File: tb/tb_stk_pipe_al.sv
// Self-checking bench for stk_pipe_al (LINES_N=4): directed scenarios then random traffic
// against a queue-based free-list model.
module tb_stk_pipe_al;
  localparam int N     = 4;
  localparam int PTR_W = $clog2(N);

  logic             clk, rst;
  logic             i_alloc, i_free;
  logic [PTR_W-1:0] i_free_ptr;
  logic             o_alloc_vld_r, o_empty_r, o_busy_r, o_err_r;
  logic [PTR_W-1:0] o_alloc_ptr_r;
  logic [PTR_W:0]   o_free_cnt_r;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int q_m[$];
  bit ready_m;
  int k_m;
  bit vld_m;
  int ptr_m;
  bit err_m;
  bit amap_m[N];

  stk_pipe_al #(.LINES_N(N)) dut (
    .clk(clk), .rst(rst),
    .i_alloc(i_alloc), .i_free(i_free), .i_free_ptr(i_free_ptr),
    .o_alloc_vld_r(o_alloc_vld_r), .o_alloc_ptr_r(o_alloc_ptr_r),
    .o_empty_r(o_empty_r), .o_busy_r(o_busy_r),
    .o_free_cnt_r(o_free_cnt_r), .o_err_r(o_err_r)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit a, input bit f, input int p, input bit r);
    bit aok, fok;
    if (r) begin
      q_m.delete();
      ready_m = 0; k_m = 0; vld_m = 0; ptr_m = 0; err_m = 0;
      for (int i = 0; i < N; i++) amap_m[i] = 0;
    end else if (!ready_m) begin
      q_m.push_back(k_m);
      k_m++;
      if (k_m == N) ready_m = 1;
      vld_m = 0;
      if (a || f) err_m = 1;
    end else begin
      aok = a && (q_m.size() > 0);
      fok = f && (q_m.size() < N);
`ifdef STK_AL_DBLFREE_CHK_EN
      fok = fok && amap_m[p];
`endif
      vld_m = 0;
      if (aok) begin
        ptr_m = q_m.pop_front();
        vld_m = 1;
        amap_m[ptr_m] = 1;
      end
      if (fok) begin
        q_m.push_back(p);
        amap_m[p] = 0;
      end
      if ((a && !aok) || (f && !fok)) err_m = 1;
    end
  endtask

  task automatic step(input bit a, input bit f, input int p, input bit r);
    rst = r; i_alloc = a; i_free = f; i_free_ptr = p[PTR_W-1:0];
    @(posedge clk);
    model(a, f, p, r);
    #1;
    chk("alloc_vld", 32'(o_alloc_vld_r), 32'(vld_m));
    chk("alloc_ptr", 32'(o_alloc_ptr_r), 32'(ptr_m));
    chk("free_cnt",  32'(o_free_cnt_r),  32'(q_m.size()));
    chk("empty",     32'(o_empty_r),     32'(q_m.size() == 0));
    chk("busy",      32'(o_busy_r),      32'(!ready_m));
    chk("err",       32'(o_err_r),       32'(err_m));
  endtask

  task automatic do_reset_init();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < N; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; i_alloc = 1'b0; i_free = 1'b0; i_free_ptr = '0;

    // Reset state and init sequence
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_busy", 32'(o_busy_r), 32'd1);
    chk("rst_empty", 32'(o_empty_r), 32'd1);
    chk("rst_cnt", 32'(o_free_cnt_r), 32'd0);
    for (int i = 0; i < N; i++) begin
      step(0, 0, 0, 0);
      chk("init_busy", 32'(o_busy_r), (i == N - 1) ? 32'd0 : 32'd1);
    end
    chk("init_cnt", 32'(o_free_cnt_r), 32'd4);
    chk("init_err", 32'(o_err_r), 32'd0);

    // Drain all lines back-to-back
    for (int i = 0; i < N; i++) begin
      step(1, 0, 0, 0);
      chk("drain_vld", 32'(o_alloc_vld_r), 32'd1);
      chk("drain_ptr", 32'(o_alloc_ptr_r), 32'(i));
    end
    chk("drain_empty", 32'(o_empty_r), 32'd1);

    // Alloc while empty is dropped and flagged
    step(1, 0, 0, 0);
    chk("empty_alloc_vld", 32'(o_alloc_vld_r), 32'd0);
    chk("empty_alloc_err", 32'(o_err_r), 32'd1);
    step(0, 0, 0, 0);
    chk("err_sticky", 32'(o_err_r), 32'd1);
    chk("ptr_hold", 32'(o_alloc_ptr_r), 32'd3);

    // Simultaneous alloc/free with a single line left
    do_reset_init();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(1, 1, 1, 0);
    chk("simul_ptr", 32'(o_alloc_ptr_r), 32'd3);
    chk("simul_cnt", 32'(o_free_cnt_r), 32'd1);
    step(1, 0, 0, 0);
    chk("after_simul_ptr", 32'(o_alloc_ptr_r), 32'd1);
    chk("simul_err", 32'(o_err_r), 32'd0);

    // Free while full is dropped
    do_reset_init();
    step(0, 1, 2, 0);
    chk("full_free_err", 32'(o_err_r), 32'd1);
    chk("full_free_cnt", 32'(o_free_cnt_r), 32'd4);

    // Free of a line that was never allocated
    do_reset_init();
    step(1, 0, 0, 0);
    step(0, 1, 1, 0);
`ifdef STK_AL_DBLFREE_CHK_EN
    chk("dbl_free_err", 32'(o_err_r), 32'd1);
    chk("dbl_free_cnt", 32'(o_free_cnt_r), 32'd3);
`else
    chk("unchk_free_err", 32'(o_err_r), 32'd0);
    chk("unchk_free_cnt", 32'(o_free_cnt_r), 32'd4);
`endif

    // Mid-operation reset discards allocations
    do_reset_init();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("midrst_cnt", 32'(o_free_cnt_r), 32'd0);
    chk("midrst_busy", 32'(o_busy_r), 32'd1);
    for (int i = 0; i < N; i++) step(0, 0, 0, 0);
    chk("reinit_cnt", 32'(o_free_cnt_r), 32'd4);
    step(1, 0, 0, 0);
    chk("reinit_ptr", 32'(o_alloc_ptr_r), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           int'($urandom_range(0, N - 1)), ($urandom_range(0, 39) == 0));
    end

    i_alloc = 1'b0; i_free = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/stk_pipe_al.md
STK_PIPE_AL -- requirements
Module: stk_pipe_al

Interface
REQ-001 SHALL have parameter LINES_N, default 16, number of stack lines managed; power of two, >=2.
REQ-002 SHALL have localparam PTR_W = $clog2(LINES_N), line-pointer width.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_alloc  in  1  allocate-line request from AD stage.
REQ-006 SHALL have port i_free  in  1  release-line request from WRBK stage.
REQ-007 SHALL have port i_free_ptr  in  PTR_W  line being released.
REQ-008 SHALL have port o_alloc_vld_r  out  1  allocated pointer valid, one-cycle pulse.
REQ-009 SHALL have port o_alloc_ptr_r  out  PTR_W  allocated line pointer.
REQ-010 SHALL have port o_empty_r  out  1  no free lines (drives AD i_al_empty_r).
REQ-011 SHALL have port o_busy_r  out  1  initialisation in progress (drives AD i_al_busy_r).
REQ-012 SHALL have port o_free_cnt_r  out  PTR_W+1  free-line count.
REQ-013 SHALL have port o_err_r  out  1  sticky protocol-error flag.

Function
REQ-014 SHALL keep free list as circular FIFO of LINES_N PTR_W-bit entries, rd/wr pointers wrapping modulo LINES_N.
REQ-015 SHALL implement FSM {INIT, READY}; INIT writes pointer k at entry k on k-th cycle after rst deasserts, k=0..LINES_N-1, incrementing count each cycle.
REQ-016 SHALL transition INIT->READY after writing entry LINES_N-1; o_busy_r SHALL fall the next cycle, exactly LINES_N cycles after rst deasserts.
REQ-017 Alloc accepted iff READY & i_alloc & ~o_empty_r; head entry popped, o_alloc_ptr_r = head and o_alloc_vld_r=1 one cycle later.
REQ-018 Free accepted iff READY & i_free & (count < LINES_N); i_free_ptr written at tail.
REQ-019 Simultaneous accepted alloc and free SHALL both complete in one cycle; count unchanged; alloc returns pre-existing head, never same-cycle freed pointer (no bypass).
REQ-020 o_free_cnt_r next = count + free_acc - alloc_acc; o_empty_r next = (next count == 0).
REQ-021 i_alloc while o_empty_r or INIT SHALL be dropped (no o_alloc_vld_r) and set o_err_r.
REQ-022 i_free while INIT or count==LINES_N SHALL be dropped and set o_err_r.
REQ-023 o_alloc_ptr_r SHALL hold last value when o_alloc_vld_r=0.
REQ-024 o_err_r SHALL remain set until reset.

Reset
REQ-025 rst SHALL force: FSM=INIT, rd/wr pointers=0, o_free_cnt_r=0, o_empty_r=1, o_busy_r=1, o_alloc_vld_r=0, o_alloc_ptr_r=0, o_err_r=0.
REQ-026 rst asserted mid-operation SHALL discard all allocations and restart INIT per REQ-015 on deassertion.
REQ-027 FIFO storage contents SHALL not require reset.

Configuration
REQ-028 Macro STK_AL_DBLFREE_CHK_EN defined: block SHALL keep LINES_N-bit allocated bitmap (set on alloc, cleared on free, all zero at reset); free of pointer whose bit is clear SHALL be dropped and set o_err_r.
REQ-029 Macro undefined: no bitmap; frees accepted per REQ-018 only.
REQ-030 Accepted alloc and free of same pointer same cycle is impossible (REQ-019) and needs no bitmap handling.

Verification (LINES_N=4)
REQ-031 Reset 2 cycles, release -> o_busy_r=1 for 4 cycles then 0; o_free_cnt_r=4; o_empty_r=0; o_err_r=0.
REQ-032 Four back-to-back i_alloc after init -> o_alloc_ptr_r=0,1,2,3 on consecutive cycles, each 1 cycle after request; then o_empty_r=1, o_free_cnt_r=0.
REQ-033 i_alloc with o_empty_r=1 -> no o_alloc_vld_r, o_free_cnt_r stays 0, o_err_r=1 until reset.
REQ-034 Count=1 (head=3), i_alloc + i_free ptr=1 same cycle -> o_alloc_ptr_r=3, count stays 1, next alloc returns 1.
REQ-035 After init, i_free ptr=2 with count=4 -> dropped, o_err_r=1; with macro and count=3 (ptr 0 allocated), free ptr=1 -> dropped, o_err_r=1; without macro accepted, count=4.
REQ-036 Alloc 2 lines, assert rst 1 cycle -> count=0, busy=1, then reinit to count=4; next alloc returns 0.
